ex_mem_stage_reg: RTL and testbench

//  Parametrised EX->MEM pipeline register with a valid/ready handshake, a 2-entry skid buffer, flush and bubble gating.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/pipe_slot.sv | 39 +++
 rtl/ex_mem_stage_reg.sv | 159 +++++++++++++++
 tb/tb_ex_mem_stage_reg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the EX->MEM pipeline register: default-width payload struct
// and the occupancy states of the skid FSM.
package pipeline_pkg;

    localparam int XLEN_DEF    = 64;
    localparam int RADDR_W_DEF = 5;

    typedef struct packed {
        logic                   MemWrite;
        logic                   MemtoReg;
        logic                   RegWrite;
        logic [XLEN_DEF-1:0]    ALU_Result;
        logic [XLEN_DEF-1:0]    wr_data;
        logic [RADDR_W_DEF-1:0] dir_rd;
    } ex_mem_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_slot.sv
// One payload register with load enable plus a valid bit; both clear to 0 on
// asynchronous active-low reset.
module pipe_slot
    import pipeline_pkg::*;
#(
    parameter type T = ex_mem_t
) (
    input  logic clk,
    input  logic rst,
    input  logic ld,
    input  logic vld_d,
    input  T     d,
    output T     q,
    output logic vld
);

    T     data_q;
    T     data_d;
    logic vld_q;

    always_comb begin
        data_d = data_q;
        if (ld) data_d = d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q   = data_q;
    assign vld = vld_q;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register: valid/ready handshake, optional 2-entry skid with a
// registered in_ready, flush, and MemWrite/RegWrite gating on the output side.
module ex_mem_stage_reg
    import pipeline_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5,
    parameter bit SKID_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               MemWrite_in,
    input  logic               MemtoReg_in,
    input  logic               RegWrite_in,
    input  logic [XLEN-1:0]    ALU_Result_in,
    input  logic [XLEN-1:0]    wr_data_in,
    input  logic [RADDR_W-1:0] dir_rd_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               MemWrite_out,
    output logic               MemtoReg_out,
    output logic               RegWrite_out,
    output logic [XLEN-1:0]    ALU_Result_out,
    output logic [XLEN-1:0]    wr_data_out,
    output logic [RADDR_W-1:0] dir_rd_out
);

    typedef struct packed {
        logic               MemWrite;
        logic               MemtoReg;
        logic               RegWrite;
        logic [XLEN-1:0]    ALU_Result;
        logic [XLEN-1:0]    wr_data;
        logic [RADDR_W-1:0] dir_rd;
    } slot_t;

    slot_t in_ent;
    slot_t main_d;
    slot_t main_q;
    logic  main_ld;
    logic  main_vld_d;
    logic  main_vld;
    logic  accept;
    logic  consume;

    assign in_ent  = '{MemWrite: MemWrite_in, MemtoReg: MemtoReg_in, RegWrite: RegWrite_in,
                       ALU_Result: ALU_Result_in, wr_data: wr_data_in, dir_rd: dir_rd_in};
    assign consume = main_vld & out_ready;
    // An entry offered during a flush is dropped, never accepted.
    assign accept  = in_valid & in_ready & ~flush;

    pipe_slot #(.T(slot_t)) u_main (
        .clk   (clk),
        .rst   (rst),
        .ld    (main_ld),
        .vld_d (main_vld_d),
        .d     (main_d),
        .q     (main_q),
        .vld   (main_vld)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic [1:0] state_q;
            logic [1:0] state_d;
            logic       in_ready_q;
            logic       in_ready_d;
            logic       skid_ld;
            logic       skid_vld_d;
            logic       skid_vld;
            logic       sel_skid;
            slot_t      skid_q;

            always_comb begin
                state_d  = state_q;
                main_ld  = 1'b0;
                skid_ld  = 1'b0;
                sel_skid = 1'b0;
                case (state_q)
                    ST_EMPTY: begin
                        if (accept) begin
                            main_ld = 1'b1;
                            state_d = ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (accept && !consume) begin
                            skid_ld = 1'b1;
                            state_d = ST_TWO;
                        end else if (consume && !accept) begin
                            state_d = ST_EMPTY;
                        end else if (accept && consume) begin
                            main_ld = 1'b1;
                        end
                    end
                    ST_TWO: begin
                        if (consume) begin
                            main_ld  = 1'b1;
                            sel_skid = 1'b1;
                            state_d  = ST_ONE;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
                if (flush) state_d = ST_EMPTY;
                in_ready_d = (state_d != ST_TWO);
                main_vld_d = (state_d != ST_EMPTY);
                skid_vld_d = (state_d == ST_TWO);
                main_d     = sel_skid ? skid_q : in_ent;
            end

            // in_ready comes from a flop so out_ready never reaches it combinationally.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    state_q    <= state_d;
                    in_ready_q <= in_ready_d;
                end
            end

            pipe_slot #(.T(slot_t)) u_skid (
                .clk   (clk),
                .rst   (rst),
                .ld    (skid_ld),
                .vld_d (skid_vld_d),
                .d     (in_ent),
                .q     (skid_q),
                .vld   (skid_vld)
            );

            assign in_ready = in_ready_q;
        end else begin : g_single
            assign in_ready = ~main_vld | out_ready;

            always_comb begin
                main_ld    = accept;
                main_d     = in_ent;
                main_vld_d = main_vld;
                if (flush)        main_vld_d = 1'b0;
                else if (accept)  main_vld_d = 1'b1;
                else if (consume) main_vld_d = 1'b0;
            end
        end
    endgenerate

    assign out_valid      = main_vld;
    assign MemWrite_out   = main_vld & main_q.MemWrite;
    assign RegWrite_out   = main_vld & main_q.RegWrite & (|main_q.dir_rd);
    assign MemtoReg_out   = main_q.MemtoReg;
    assign ALU_Result_out = main_q.ALU_Result;
    assign wr_data_out    = main_q.wr_data;
    assign dir_rd_out     = main_q.dir_rd;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for ex_mem_stage_reg: skid and single-slot builds side by side, both
// compared every cycle against queue models of the handshake rules.
module tb_ex_mem_stage_reg;

    localparam int XLEN = 64;
    localparam int RW   = 5;

    typedef struct {
        bit            mw;
        bit            m2r;
        bit            rw;
        bit [XLEN-1:0] alu;
        bit [XLEN-1:0] wd;
        bit [RW-1:0]   rd;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic            mw_in = 1'b0, m2r_in = 1'b0, rw_in = 1'b0;
    logic [XLEN-1:0] alu_in = '0, wd_in = '0;
    logic [RW-1:0]   rd_in = '0;

    logic            in_ready_s, out_valid_s, mw_s, m2r_s, rw_s;
    logic [XLEN-1:0] alu_s, wd_s;
    logic [RW-1:0]   rd_s;
    logic            in_ready_f, out_valid_f, mw_f, m2r_f, rw_f;
    logic [XLEN-1:0] alu_f, wd_f;
    logic [RW-1:0]   rd_f;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t qs[$];
    ent_t qf[$];

    always #5 clk = ~clk;

    ex_mem_stage_reg #(.XLEN(XLEN), .RADDR_W(RW), .SKID_EN(1'b1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
        .MemWrite_in(mw_in), .MemtoReg_in(m2r_in), .RegWrite_in(rw_in),
        .ALU_Result_in(alu_in), .wr_data_in(wd_in), .dir_rd_in(rd_in),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .MemWrite_out(mw_s), .MemtoReg_out(m2r_s), .RegWrite_out(rw_s),
        .ALU_Result_out(alu_s), .wr_data_out(wd_s), .dir_rd_out(rd_s)
    );

    ex_mem_stage_reg #(.XLEN(XLEN), .RADDR_W(RW), .SKID_EN(1'b0)) u_flat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_f),
        .MemWrite_in(mw_in), .MemtoReg_in(m2r_in), .RegWrite_in(rw_in),
        .ALU_Result_in(alu_in), .wr_data_in(wd_in), .dir_rd_in(rd_in),
        .out_valid(out_valid_f), .out_ready(out_ready),
        .MemWrite_out(mw_f), .MemtoReg_out(m2r_f), .RegWrite_out(rw_f),
        .ALU_Result_out(alu_f), .wr_data_out(wd_f), .dir_rd_out(rd_f)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ent_t rnd_ent();
        ent_t e;
        e.mw  = 1'($urandom_range(0, 1));
        e.m2r = 1'($urandom_range(0, 1));
        e.rw  = 1'($urandom_range(0, 1));
        e.alu = {$urandom, $urandom};
        e.wd  = {$urandom, $urandom};
        e.rd  = ($urandom_range(0, 3) == 0) ? '0 : RW'($urandom);
        return e;
    endfunction

    function automatic ent_t mk_ent(input bit mw, input bit rw, input int alu, input int rd);
        ent_t e;
        e.mw  = mw;
        e.m2r = alu[0];
        e.rw  = rw;
        e.alu = XLEN'(alu);
        e.wd  = XLEN'(alu) ^ 64'hA5A5_0000_0000_5A5A;
        e.rd  = RW'(rd);
        return e;
    endfunction

    // Visible MEM-side view: head of the queue, with stores gated by valid and
    // register writes also dropped for x0.
    task automatic check_out();
        chk("out_valid_s", out_valid_s, qs.size() > 0);
        chk("memwrite_s", mw_s, (qs.size() > 0) ? qs[0].mw : 1'b0);
        chk("regwrite_s", rw_s, (qs.size() > 0) ? (qs[0].rw && qs[0].rd != 0) : 1'b0);
        if (qs.size() > 0)
            chk("payload_s", {m2r_s, alu_s, wd_s, rd_s}, {qs[0].m2r, qs[0].alu, qs[0].wd, qs[0].rd});
        chk("out_valid_f", out_valid_f, qf.size() > 0);
        chk("memwrite_f", mw_f, (qf.size() > 0) ? qf[0].mw : 1'b0);
        chk("regwrite_f", rw_f, (qf.size() > 0) ? (qf[0].rw && qf[0].rd != 0) : 1'b0);
        if (qf.size() > 0)
            chk("payload_f", {m2r_f, alu_f, wd_f, rd_f}, {qf[0].m2r, qf[0].alu, qf[0].wd, qf[0].rd});
    endtask

    task automatic model_step(inout ent_t q[$], input int cap, input bit rdy,
                              input bit iv, input bit ordy, input bit fl, input ent_t e);
        bit con;
        bit acc;
        con = (q.size() > 0) && ordy;
        acc = iv && rdy && !fl;
        if (fl) q.delete();
        else begin
            if (con) void'(q.pop_front());
            if (acc && q.size() < cap) q.push_back(e);
        end
    endtask

    // One clock: drive at negedge, check ready, model the edge, check outputs.
    task automatic cycle(input bit iv, input bit ordy, input bit fl, input ent_t e);
        bit rdy_s;
        bit rdy_f;
        in_valid = iv; out_ready = ordy; flush = fl;
        mw_in = e.mw; m2r_in = e.m2r; rw_in = e.rw;
        alu_in = e.alu; wd_in = e.wd; rd_in = e.rd;
        #1;
        rdy_s = (qs.size() < 2);
        rdy_f = (qf.size() == 0) || ordy;
        chk("in_ready_s", in_ready_s, rdy_s);
        chk("in_ready_f", in_ready_f, rdy_f);
        @(posedge clk);
        model_step(qs, 2, rdy_s, iv, ordy, fl, e);
        model_step(qf, 1, rdy_f, iv, ordy, fl, e);
        @(negedge clk);
        check_out();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s"}, {out_valid_s, mw_s, m2r_s, rw_s, alu_s, wd_s, rd_s}, '0);
        chk({tag, "_f"}, {out_valid_f, mw_f, m2r_f, rw_f, alu_f, wd_f, rd_f}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        ent_t e;
        ent_t held;
        ent_t idle;
        idle = mk_ent(0, 0, 0, 0);

        // Power-on reset.
        repeat (2) @(negedge clk);
        check_all_zero("reset_out");
        rst = 1'b1;
        @(negedge clk);
        chk("reset_in_ready_s", in_ready_s, 1'b1);
        chk("reset_in_ready_f", in_ready_f, 1'b1);
        check_out();

        // Streaming, out_ready held high.
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, mk_ent(i % 2, 1, i, i + 1));
        cycle(0, 1, 0, idle);

        // Stall: three offers with out_ready low, then release and drain.
        cycle(1, 0, 0, mk_ent(1, 1, 100, 3));
        cycle(1, 0, 0, mk_ent(0, 1, 101, 4));
        held = mk_ent(1, 0, 102, 5);
        cycle(1, 0, 0, held);
        chk("stall_ready_s", in_ready_s, 1'b0);
        chk("stall_hold_alu", alu_s, 64'd100);
        cycle(1, 1, 0, held);
        cycle(1, 1, 0, held);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, idle);

        // Flush while full with a same-cycle offer; the offer must never appear.
        cycle(1, 0, 0, mk_ent(1, 1, 200, 7));
        cycle(1, 0, 0, mk_ent(1, 1, 201, 8));
        cycle(1, 1, 1, mk_ent(1, 1, 202, 9));
        chk("flush_valid_s", out_valid_s, 1'b0);
        chk("flush_mw_s", mw_s, 1'b0);
        chk("flush_rw_s", rw_s, 1'b0);
        for (int i = 0; i < 2; i++) cycle(0, 1, 0, idle);

        // x0 write suppression.
        cycle(1, 0, 0, mk_ent(1, 1, 300, 0));
        chk("x0_rw_s", rw_s, 1'b0);
        chk("x0_mw_s", mw_s, 1'b1);
        chk("x0_rw_f", rw_f, 1'b0);
        chk("x0_mw_f", mw_f, 1'b1);
        cycle(0, 1, 0, idle);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            e = rnd_ent();
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0, e);
        end

        // Asynchronous reset in mid-cycle while holding entries.
        cycle(1, 0, 0, mk_ent(1, 1, 400, 1));
        cycle(1, 0, 0, mk_ent(1, 1, 401, 2));
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        qs.delete();
        qf.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready_s", in_ready_s, 1'b1);
        chk("post_reset_ready_f", in_ready_f, 1'b1);
        check_out();
        cycle(1, 1, 0, mk_ent(0, 1, 500, 6));
        cycle(0, 1, 0, idle);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
